// File: rtl/mcycle_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide engine.
// The EX stage is the master; the engine is the slave.
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle; MCYCLE_SIGNED_EN adds two's complement.
// Latency: Busy for WIDTH+1 cycles from the Start cycle, Done pulses the cycle after.
// Backpressure: Busy stalls the pipeline; Start is ignored outside IDLE, so a held Start cannot relaunch.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input logic         CLK,
  input logic         RESET,
  mcycle_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             opDiv;
  logic [WIDTH-1:0] accA;
  logic [WIDTH-1:0] accB;
  logic [WIDTH-1:0] opM;
  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;
  logic             doneQ;

  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] nextA;
  logic [WIDTH-1:0] nextB;
  logic [WIDTH-1:0] fin1;
  logic [WIDTH-1:0] fin2;

`ifdef MCYCLE_SIGNED_EN
  logic               sign1;
  logic               sign2;
  logic               negLo;
  logic               negRem;
  logic [2*WIDTH-1:0] prod;
`endif

  assign bus.Busy    = !RESET && (((state == IDLE) && bus.Start) || (state == COMPUTING));
  assign bus.Done    = doneQ;
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;

  // Iteration operates on magnitudes; signs are reapplied on the final edge.
  always_comb begin
`ifdef MCYCLE_SIGNED_EN
    sign1 = bus.Operand1[WIDTH-1];
    sign2 = bus.Operand2[WIDTH-1];
    magA  = sign1 ? -bus.Operand1 : bus.Operand1;
    magB  = sign2 ? -bus.Operand2 : bus.Operand2;
`else
    magA  = bus.Operand1;
    magB  = bus.Operand2;
`endif
  end

  // accA: product high half / partial remainder. accB: multiplier / dividend shifting into quotient.
  always_comb begin
    mulSum   = {1'b0, accA} + (accB[0] ? {1'b0, opM} : '0);
    divShift = {accA, accB[WIDTH-1]};
    divFits  = (divShift >= {1'b0, opM});
    nextA    = '0;
    nextB    = '0;
    if (opDiv) begin
      if (divFits) begin
        nextA = WIDTH'(divShift - {1'b0, opM});
        nextB = {accB[WIDTH-2:0], 1'b1};
      end else begin
        nextA = divShift[WIDTH-1:0];
        nextB = {accB[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextA = mulSum[WIDTH:1];
      nextB = {mulSum[0], accB[WIDTH-1:1]};
    end
  end

  always_comb begin
    fin1 = nextB;
    fin2 = nextA;
`ifdef MCYCLE_SIGNED_EN
    prod = {nextA, nextB};
    if (!opDiv) begin
      if (negLo) prod = -prod;
      fin1 = prod[WIDTH-1:0];
      fin2 = prod[2*WIDTH-1:WIDTH];
    end else begin
      // Divide by zero keeps the all-ones quotient regardless of sign.
      if (negLo && (opM != '0)) fin1 = -nextB;
      if (negRem) fin2 = -nextA;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      count <= '0;
      opDiv <= 1'b0;
      accA  <= '0;
      accB  <= '0;
      opM   <= '0;
      res1  <= '0;
      res2  <= '0;
      doneQ <= 1'b0;
`ifdef MCYCLE_SIGNED_EN
      negLo  <= 1'b0;
      negRem <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          doneQ <= 1'b0;
          if (bus.Start) begin
            state <= COMPUTING;
            count <= '0;
            opDiv <= bus.MCycleOp;
            accA  <= '0;
            accB  <= bus.MCycleOp ? magA : magB;
            opM   <= bus.MCycleOp ? magB : magA;
`ifdef MCYCLE_SIGNED_EN
            negLo  <= sign1 ^ sign2;
            negRem <= sign1;
`endif
          end
        end
        COMPUTING: begin
          accA  <= nextA;
          accB  <= nextB;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            res1  <= fin1;
            res2  <= fin2;
            doneQ <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          doneQ <= 1'b0;
          state <= IDLE;
        end
        default: begin
          doneQ <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Randomised and directed bench for mcycle_unit against a cycle-timeline reference model.
module tb_mcycle_unit;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET;
  int   nChecks = 0;
  int   nErr = 0;

  mcycle_unit_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void refOp(input bit op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q1, output logic [31:0] q2);
    logic [63:0] p;
`ifdef MCYCLE_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      p  = 64'(sa * sb);
      q1 = p[31:0];
      q2 = p[63:32];
    end else if (b == 0) begin
      q1 = '1;
      q2 = a;
    end else begin
      q1 = 32'(sa / sb);
      q2 = 32'(sa % sb);
    end
`else
    if (!op) begin
      p  = {32'b0, a} * {32'b0, b};
      q1 = p[31:0];
      q2 = p[63:32];
    end else if (b == 0) begin
      q1 = '1;
      q2 = a;
    end else begin
      q1 = a / b;
      q2 = a % b;
    end
`endif
  endfunction

  // Timeline model: an op accepted in cycle s is Busy in s..s+W and Done in s+W+1.
  int          cyc = 0;
  bit          mActive = 0;
  int          mS = 0;
  bit          known = 0;
  logic [31:0] mR1, mR2, mP1, mP2;

  always @(negedge CLK) begin
    bit idle;
    bit expBusy;
    bit expDone;
    if (mActive && cyc == mS + W + 1) begin
      mR1 = mP1;
      mR2 = mP2;
    end
    expDone = mActive && (cyc == mS + W + 1);
    idle    = !(mActive && cyc <= mS + W + 1);
    expBusy = !RESET && ((mActive && cyc >= mS && cyc <= mS + W) || (idle && bus.Start));
    check("model_busy", 64'(bus.Busy), 64'(expBusy));
    if (known) begin
      check("model_done", 64'(bus.Done), 64'(expDone));
      check("model_result1", 64'(bus.Result1), 64'(mR1));
      check("model_result2", 64'(bus.Result2), 64'(mR2));
    end
    if (RESET) begin
      mActive = 0;
      mR1 = '0;
      mR2 = '0;
      known = 1;
    end else if (idle && bus.Start) begin
      mActive = 1;
      mS = cyc;
      refOp(bus.MCycleOp, bus.Operand1, bus.Operand2, mP1, mP2);
    end
    cyc++;
  end

  task automatic drive(input bit rst, input bit st, input bit op, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK);
    #1;
    RESET        = rst;
    bus.Start    = st;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Launch one op, then scramble inputs while it runs; checks latency and literal results.
  task automatic runOp(input string nm, input bit op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e1, input logic [31:0] e2);
    int busyN;
    int doneAt;
    busyN  = 0;
    doneAt = -1;
    drive(0, 1, op, a, b);
    for (int k = 0; k < 45 && doneAt < 0; k++) begin
      if (k > 0) drive(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      @(negedge CLK);
      if (bus.Busy) busyN++;
      if (bus.Done) doneAt = k;
    end
    check({"done_cycle_", nm}, 64'(doneAt), 64'(W + 1));
    check({"busy_cycles_", nm}, 64'(busyN), 64'(W + 1));
    check({"result1_", nm}, 64'(bus.Result1), 64'(e1));
    check({"result2_", nm}, 64'(bus.Result2), 64'(e2));
  endtask

  initial begin
    int doneN;
    RESET        = 1'b1;
    bus.Start    = 1'b0;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 5, 5);
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("reset_busy", 64'(bus.Busy), 64'd0);
    check("reset_done", 64'(bus.Done), 64'd0);
    check("reset_result1", 64'(bus.Result1), 64'd0);
    check("reset_result2", 64'(bus.Result2), 64'd0);

    runOp("mul_7x6", 0, 32'd7, 32'd6, 32'h2A, 32'h0);
    runOp("div_100_7", 1, 32'd100, 32'd7, 32'd14, 32'd2);
    runOp("div_by_zero", 1, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234);
    runOp("div_small", 1, 32'd5, 32'd9, 32'd0, 32'd5);
`ifdef MCYCLE_SIGNED_EN
    runOp("mul_m1xm1", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0);
    runOp("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runOp("mul_m2x3", 0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
    runOp("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
`else
    runOp("mul_max", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE);
    runOp("div_max_3", 1, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'h0);
`endif

    // Start held through DONE: one op, one Done pulse, relaunch in the following IDLE cycle.
    doneN = 0;
    drive(0, 1, 0, 32'd3, 32'd5);
    for (int k = 0; k <= W + 1; k++) begin
      if (k > 0) drive(0, 1, 1'($urandom), $urandom, $urandom);
      @(negedge CLK);
      if (bus.Done) doneN++;
    end
    check("held_done_pulses", 64'(doneN), 64'd1);
    check("held_result1", 64'(bus.Result1), 64'd15);
    runOp("held_relaunch", 0, 32'd9, 32'd9, 32'd81, 32'd0);

    // Reset in cycle 10 of a multiply.
    drive(0, 1, 0, 32'd7, 32'd6);
    for (int k = 1; k < 10; k++) drive(0, 0, 0, $urandom, $urandom);
    drive(1, 0, 0, 0, 0);
    @(negedge CLK);
    check("reset_mid_busy_forced", 64'(bus.Busy), 64'd0);
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("reset_mid_busy", 64'(bus.Busy), 64'd0);
    check("reset_mid_done", 64'(bus.Done), 64'd0);
    check("reset_mid_result1", 64'(bus.Result1), 64'd0);
    check("reset_mid_result2", 64'(bus.Result2), 64'd0);

    for (int k = 0; k < 2500; k++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, 1'($urandom), pick(), pick());
    end
    drive(0, 0, 0, 0, 0);
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
